// File: rtl/sdram_arbit.sv
// Central SDRAM command-bus scheduler: init hand-off, refresh timer and ref/write/read arbitration.
// Define SDRAM_RD_FIRST_EN to favour reads over writes; refresh always wins.
module sdram_arbit #(
   parameter int unsigned CNT_REF = 780,
   parameter logic [3:0]  NOP_CMD = 4'b0111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  init_cmd,
   input  logic [11:0] init_addr,
   input  logic        flag_init_end,
   input  logic [3:0]  aref_cmd,
   input  logic [11:0] aref_addr,
   input  logic        aref_end,
   input  logic        wr_req,
   input  logic [3:0]  wr_cmd,
   input  logic [11:0] wr_addr,
   input  logic [1:0]  wr_ba,
   input  logic        wr_end,
   input  logic        rd_req,
   input  logic [3:0]  rd_cmd,
   input  logic [11:0] rd_addr,
   input  logic [1:0]  rd_ba,
   input  logic        rd_end,
   output logic        aref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic        ref_req,
   output logic        ref_ovf,
   output logic [3:0]  sdram_cmd,
   output logic [11:0] sdram_addr,
   output logic [1:0]  sdram_ba
);

   // One-hot so each grant is a single flop output and cannot glitch.
   localparam logic [4:0] StInit  = 5'b00001;
   localparam logic [4:0] StArbit = 5'b00010;
   localparam logic [4:0] StAref  = 5'b00100;
   localparam logic [4:0] StWrite = 5'b01000;
   localparam logic [4:0] StRead  = 5'b10000;

   localparam logic [15:0] CntLast = 16'(CNT_REF - 1);

   logic [4:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ref_req_q, ref_req_d;
   logic        ref_ovf_q, ref_ovf_d;
   logic        cnt_wrap;
   logic        aref_entry;

   always_comb begin
      cnt_wrap = 1'b0;
      cnt_d    = cnt_q + 16'd1;
      if (state_q == StInit) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         cnt_d    = '0;
         cnt_wrap = 1'b1;
      end
   end

   assign aref_entry = (state_q == StArbit) && ref_req_q;

   // A wrap on the entry edge re-arms the request instead of flagging overflow.
   always_comb begin
      ref_req_d = ref_req_q;
      ref_ovf_d = ref_ovf_q;
      if (cnt_wrap) begin
         ref_req_d = 1'b1;
         if (ref_req_q && !aref_entry) begin
            ref_ovf_d = 1'b1;
         end
      end else if (aref_entry) begin
         ref_req_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit: begin
            if (flag_init_end) begin
               state_d = StArbit;
            end
         end
         StArbit: begin
            if (ref_req_q) begin
               state_d = StAref;
`ifdef SDRAM_RD_FIRST_EN
            end else if (rd_req) begin
               state_d = StRead;
            end else if (wr_req) begin
               state_d = StWrite;
`else
            end else if (wr_req) begin
               state_d = StWrite;
            end else if (rd_req) begin
               state_d = StRead;
`endif
            end
         end
         StAref: begin
            if (aref_end) begin
               state_d = StArbit;
            end
         end
         StWrite: begin
            if (wr_end) begin
               state_d = StArbit;
            end
         end
         StRead: begin
            if (rd_end) begin
               state_d = StArbit;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StInit;
         cnt_q     <= '0;
         ref_req_q <= 1'b0;
         ref_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ref_req_q <= ref_req_d;
         ref_ovf_q <= ref_ovf_d;
      end
   end

   assign aref_en = state_q[2];
   assign wr_en   = state_q[3];
   assign rd_en   = state_q[4];
   assign ref_req = ref_req_q;
   assign ref_ovf = ref_ovf_q;

   always_comb begin
      sdram_cmd  = NOP_CMD;
      sdram_addr = '0;
      sdram_ba   = '0;
      unique case (state_q)
         StInit: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         StArbit: begin
            sdram_cmd  = NOP_CMD;
         end
         StAref: begin
            sdram_cmd  = aref_cmd;
            sdram_addr = aref_addr;
         end
         StWrite: begin
            sdram_cmd  = wr_cmd;
            sdram_addr = wr_addr;
            sdram_ba   = wr_ba;
         end
         StRead: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
            sdram_ba   = rd_ba;
         end
         default: begin
            sdram_cmd  = NOP_CMD;
         end
      endcase
   end

`ifndef SYNTHESIS
   state_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot(state_q));
   cnt_range_a    : assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntLast);
`endif

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: randomized stimulus against a cycle-level ownership model.
module tb_sdram_arbit;

   localparam int CNT_REF = 780;
   localparam logic [3:0] NOP = 4'b0111;
`ifdef SDRAM_RD_FIRST_EN
   localparam bit RdFirst = 1'b1;
`else
   localparam bit RdFirst = 1'b0;
`endif

   localparam int OwnInit = 0;
   localparam int OwnIdle = 1;
   localparam int OwnAref = 2;
   localparam int OwnWr   = 3;
   localparam int OwnRd   = 4;

   logic        clk, rst_n;
   logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
   logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
   logic [1:0]  wr_ba, rd_ba;
   logic        flag_init_end, aref_end, wr_req, wr_end, rd_req, rd_end;
   logic        aref_en, wr_en, rd_en, ref_req, ref_ovf;
   logic [3:0]  sdram_cmd;
   logic [11:0] sdram_addr;
   logic [1:0]  sdram_ba;

   int checks = 0;
   int failures = 0;

   sdram_arbit #(.CNT_REF(CNT_REF), .NOP_CMD(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
      .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_end(aref_end),
      .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba), .wr_end(wr_end),
      .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba), .rd_end(rd_end),
      .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .ref_req(ref_req), .ref_ovf(ref_ovf),
      .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the bus, cycles since init, and refresh bookkeeping.
   int   m_own, m_since;
   logic m_req, m_ovf, m_expire, m_ref_grant;

   assign m_expire    = (m_own != OwnInit) && (((m_since + 1) % CNT_REF) == 0);
   assign m_ref_grant = (m_own == OwnIdle) && m_req;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_own   <= OwnInit;
         m_since <= 0;
         m_req   <= 1'b0;
         m_ovf   <= 1'b0;
      end else begin
         m_since <= (m_own == OwnInit) ? 0 : m_since + 1;
         m_req   <= m_expire | (m_req & ~m_ref_grant);
         m_ovf   <= m_ovf | (m_expire & m_req & ~m_ref_grant);
         case (m_own)
            OwnInit: if (flag_init_end) m_own <= OwnIdle;
            OwnIdle: begin
               if (m_req) m_own <= OwnAref;
               else if (RdFirst && rd_req) m_own <= OwnRd;
               else if (wr_req) m_own <= OwnWr;
               else if (rd_req) m_own <= OwnRd;
            end
            OwnAref: if (aref_end) m_own <= OwnIdle;
            OwnWr:   if (wr_end) m_own <= OwnIdle;
            OwnRd:   if (rd_end) m_own <= OwnIdle;
            default: m_own <= OwnInit;
         endcase
      end
   end

   logic [3:0]  exp_cmd;
   logic [11:0] exp_addr;
   logic [1:0]  exp_ba;
   logic [24:0] exp_vec, dut_vec;

   always_comb begin
      exp_cmd  = NOP;
      exp_addr = '0;
      exp_ba   = '0;
      case (m_own)
         OwnInit: begin exp_cmd = init_cmd; exp_addr = init_addr; end
         OwnAref: begin exp_cmd = aref_cmd; exp_addr = aref_addr; end
         OwnWr:   begin exp_cmd = wr_cmd; exp_addr = wr_addr; exp_ba = wr_ba; end
         OwnRd:   begin exp_cmd = rd_cmd; exp_addr = rd_addr; exp_ba = rd_ba; end
         default: ;
      endcase
   end

   assign exp_vec = {m_own == OwnAref, m_own == OwnWr, m_own == OwnRd, m_req, m_ovf,
                     exp_cmd, exp_addr, exp_ba};
   assign dut_vec = {aref_en, wr_en, rd_en, ref_req, ref_ovf, sdram_cmd, sdram_addr, sdram_ba};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_bus();
      init_cmd  = 4'($urandom);  init_addr = 12'($urandom);
      aref_cmd  = 4'($urandom);  aref_addr = 12'($urandom);
      wr_cmd    = 4'($urandom);  wr_addr   = 12'($urandom); wr_ba = 2'($urandom);
      rd_cmd    = 4'($urandom);  rd_addr   = 12'($urandom); rd_ba = 2'($urandom);
   endtask

   task automatic idle_inputs();
      wr_req = 1'b0; rd_req = 1'b0;
      aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      flag_init_end = 1'b0;
      rand_bus();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({aref_en, wr_en, rd_en, ref_req, ref_ovf} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b want 00000", {aref_en, wr_en, rd_en, ref_req, ref_ovf});
      end
      for (int i = 0; i < 3; i++) begin
         rand_bus();
         #1;
         checks++;
         if ({sdram_cmd, sdram_addr, sdram_ba} !== {init_cmd, init_addr, 2'b00}) begin
            failures++;
            $display("FAIL reset_bus: got %h/%h/%h want %h/%h/0", sdram_cmd, sdram_addr,
                     sdram_ba, init_cmd, init_addr);
         end
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
         failures++;
         $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec);
      end
   endtask

   // Leaves reset, asserts flag_init_end after 20 cycles and times the first refresh request.
   task automatic test_init(input string tag);
      int n;
      flag_init_end = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (sdram_cmd !== init_cmd || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL %s_track: got %h want %h", tag, dut_vec, exp_vec);
         end
         rand_bus();
      end
      flag_init_end = 1'b1;
      tick();
      checks++;
      if (sdram_cmd !== NOP || sdram_addr !== 12'd0 || sdram_ba !== 2'd0) begin
         failures++;
         $display("FAIL %s_nop: got %h/%h/%h want 7/000/0", tag, sdram_cmd, sdram_addr, sdram_ba);
      end
      n = 0;
      while (ref_req !== 1'b1 && n < 2 * CNT_REF) begin
         tick();
         n++;
         rand_bus();
      end
      checks++;
      if (n != CNT_REF) begin
         failures++;
         $display("FAIL %s_first_ref: got %0d cycles want %0d", tag, n, CNT_REF);
      end
      tick();
      checks++;
      if (aref_en !== 1'b1 || ref_req !== 1'b0) begin
         failures++;
         $display("FAIL %s_ref_grant: got aref_en=%b ref_req=%b want 1 0", tag, aref_en, ref_req);
      end
      aref_end = 1'b1;
      tick();
      aref_end = 1'b0;
      checks++;
      if (dut_vec !== exp_vec || aref_en !== 1'b0) begin
         failures++;
         $display("FAIL %s_ref_done: got %h want %h", tag, dut_vec, exp_vec);
      end
   endtask

   task automatic test_priority();
      wr_req = 1'b1; rd_req = 1'b1;
      tick();
      checks++;
      if ((RdFirst ? {rd_en, wr_en} : {wr_en, rd_en}) !== 2'b10) begin
         failures++;
         $display("FAIL prio_first: got wr_en=%b rd_en=%b", wr_en, rd_en);
      end
      if (RdFirst) rd_req = 1'b0; else wr_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_bus();
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL prio_hold: got %h want %h", dut_vec, exp_vec);
         end
      end
      if (RdFirst) rd_end = 1'b1; else wr_end = 1'b1;
      tick();
      rd_end = 1'b0; wr_end = 1'b0;
      checks++;
      if ({wr_en, rd_en, aref_en} !== 3'b000 || sdram_cmd !== NOP) begin
         failures++;
         $display("FAIL prio_gap: got en=%b cmd=%h want 000 7", {wr_en, rd_en, aref_en}, sdram_cmd);
      end
      tick();
      checks++;
      if ((RdFirst ? {rd_en, wr_en} : {wr_en, rd_en}) !== 2'b01) begin
         failures++;
         $display("FAIL prio_second: got wr_en=%b rd_en=%b", wr_en, rd_en);
      end
      wr_req = 1'b0; rd_req = 1'b0;
      tick();
      wr_end = 1'b1; rd_end = 1'b1;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_no_preempt();
      int n;
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      rd_req = 1'b1;
      checks++;
      if (wr_en !== 1'b1) begin
         failures++;
         $display("FAIL nopre_grant: got wr_en=%b want 1", wr_en);
      end
      n = 0;
      while (ref_req !== 1'b1 && n < 2 * CNT_REF) begin
         rand_bus();
         tick();
         n++;
      end
      checks++;
      if (ref_req !== 1'b1) begin
         failures++;
         $display("FAIL nopre_ref_wait: got ref_req=%b want 1 within %0d", ref_req, 2 * CNT_REF);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (wr_en !== 1'b1 || aref_en !== 1'b0 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL nopre_hold: got %h want %h", dut_vec, exp_vec);
         end
      end
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      tick();
      checks++;
      if (aref_en !== 1'b1 || rd_en !== 1'b0 || ref_req !== 1'b0) begin
         failures++;
         $display("FAIL nopre_ref_first: got aref_en=%b rd_en=%b ref_req=%b want 1 0 0",
                  aref_en, rd_en, ref_req);
      end
      aref_end = 1'b1;
      tick();
      aref_end = 1'b0;
      tick();
      checks++;
      if (rd_en !== 1'b1) begin
         failures++;
         $display("FAIL nopre_rd_after: got rd_en=%b want 1", rd_en);
      end
      rd_req = 1'b0;
      rd_end = 1'b1;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_wrap_same_edge();
      int n;
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      n = 0;
      while (!(m_req && (m_since % CNT_REF) == CNT_REF - 2) && n < 3 * CNT_REF) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 3 * CNT_REF) begin
         failures++;
         $display("FAIL wrap_setup: got timeout after %0d want alignment", n);
      end
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      checks++;
      if (ref_req !== 1'b1 || {aref_en, wr_en, rd_en} !== 3'b000) begin
         failures++;
         $display("FAIL wrap_pre: got ref_req=%b en=%b want 1 000", ref_req, {aref_en, wr_en, rd_en});
      end
      tick();
      checks++;
      if (aref_en !== 1'b1 || ref_req !== 1'b1 || ref_ovf !== 1'b0) begin
         failures++;
         $display("FAIL wrap_same_edge: got aref_en=%b ref_req=%b ref_ovf=%b want 1 1 0",
                  aref_en, ref_req, ref_ovf);
      end
      aref_end = 1'b1;
      tick();
      aref_end = 1'b0;
      tick();
      checks++;
      if (aref_en !== 1'b1 || ref_req !== 1'b0 || ref_ovf !== 1'b0) begin
         failures++;
         $display("FAIL wrap_second_ref: got aref_en=%b ref_req=%b ref_ovf=%b want 1 0 0",
                  aref_en, ref_req, ref_ovf);
      end
      aref_end = 1'b1;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_overflow();
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      for (int i = 0; i < 2 * CNT_REF + 5; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL ovf_track: got %h want %h", dut_vec, exp_vec);
         end
      end
      checks++;
      if (ref_ovf !== 1'b1 || wr_en !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: got ref_ovf=%b wr_en=%b want 1 1", ref_ovf, wr_en);
      end
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      tick();
      aref_end = 1'b1;
      tick();
      aref_end = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (ref_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky: got ref_ovf=%b want 1", ref_ovf);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         rand_bus();
         wr_req   = 1'($urandom_range(0, 1));
         rd_req   = 1'($urandom_range(0, 1));
         aref_end = ($urandom_range(0, 5) == 0);
         wr_end   = ($urandom_range(0, 5) == 0);
         rd_end   = ($urandom_range(0, 5) == 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL random_%0d: got %h want %h", i, dut_vec, exp_vec);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_read();
      int n;
      rd_req = 1'b1; aref_end = 1'b1; wr_end = 1'b1; rd_end = 1'b0;
      n = 0;
      while (rd_en !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (rd_en !== 1'b1) begin
         failures++;
         $display("FAIL rst_rd_grant: got rd_en=%b want 1", rd_en);
      end
      idle_inputs();
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({aref_en, wr_en, rd_en, ref_req} !== 4'b0000 || sdram_cmd !== init_cmd ||
          sdram_addr !== init_addr || sdram_ba !== 2'b00) begin
         failures++;
         $display("FAIL rst_async: got en=%b cmd=%h addr=%h want 0000 %h %h",
                  {aref_en, wr_en, rd_en, ref_req}, sdram_cmd, sdram_addr, init_cmd, init_addr);
      end
      tick();
      test_init("reinit");
   endtask

   initial begin
      test_reset();
      test_init("init");
      test_priority();
      test_no_preempt();
      test_wrap_same_edge();
      test_overflow();
      test_random();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Central scheduler for the SDRAM controller. Holds the command bus for the power-up init sequencer until init completes, then shares the SDRAM command/address/bank pins between the auto-refresh, write and read sub-blocks. It also owns the periodic refresh timer. It sits between the sub-blocks and the SDRAM pin registers.

## Interface
Parameters:
- CNT_REF, 780, refresh interval in clk cycles (15.6 us at 50 MHz); legal range 2..65535
- NOP_CMD, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n}

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- init_cmd  in  4  init sequencer command
- init_addr  in  12  init sequencer address
- flag_init_end  in  1  init sequence complete (level)
- aref_cmd / aref_addr  in  4 / 12  refresh sub-block command/address
- aref_end  in  1  one-cycle pulse: refresh done
- wr_req  in  1  write sub-block request (level, held until granted)
- wr_cmd / wr_addr / wr_ba  in  4 / 12 / 2  write sub-block bus
- wr_end  in  1  one-cycle pulse: write burst done
- rd_req  in  1  read sub-block request (level)
- rd_cmd / rd_addr / rd_ba  in  4 / 12 / 2  read sub-block bus
- rd_end  in  1  one-cycle pulse: read burst done
- aref_en / wr_en / rd_en  out  1  grant; high for the whole time the state owns the bus
- ref_req  out  1  refresh pending; sub-blocks end the current burst early when they see it
- ref_ovf  out  1  sticky: a refresh interval expired while ref_req was still set
- sdram_cmd  out  4  muxed command
- sdram_addr  out  12  muxed address
- sdram_ba  out  2  muxed bank

## Operation
- State register with five states: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- INIT: moves to ARBIT on the clock edge where flag_init_end=1.
- ARBIT: on each edge, selects in priority order ref_req > wr_req > rd_req and moves to AREF, WRITE or READ. With nothing pending it stays in ARBIT.
- AREF / WRITE / READ: return to ARBIT on the matching aref_end, wr_end or rd_end. End pulses that do not match the current state are ignored.
- Grant outputs are a pure decode of the state register: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). They are glitch-free.
- Bus mux is combinational from the state:
  - INIT: init_cmd, init_addr, ba=0
  - ARBIT: NOP_CMD, addr=0, ba=0
  - AREF: aref_cmd, aref_addr, ba=0
  - WRITE: wr_* signals
  - READ: rd_* signals
- Refresh timer, 16 bits:
  - Held at 0 in INIT.
  - Otherwise increments every cycle and wraps to 0 at CNT_REF-1.
  - On the wrap cycle it sets ref_req.
  - ref_req clears on entry to AREF.
  - If a wrap occurs while ref_req=1, ref_req stays 1 and ref_ovf sets. ref_ovf clears only on reset.
- The arbiter never preempts. A WRITE or READ in progress keeps the bus until its end pulse, even with ref_req set.

## Timing
- Reset values:
  - state=INIT, refresh counter=0
  - ref_req=0, ref_ovf=0
  - aref_en=wr_en=rd_en=0
  - sdram_cmd=init_cmd, sdram_addr=init_addr, sdram_ba=0
- Grant latency: a request sampled in ARBIT at edge N gives the grant high from edge N, visible in cycle N+1.
- End handling: an end pulse at edge M drops the grant after edge M. ARBIT lasts at least one cycle, so re-arbitration happens at edge M+1 at the earliest, and each transaction is separated by at least one NOP cycle.
- Timer wrap and entry to AREF on the same edge: ref_req clears, and the new expiry is not lost. ref_req=1 again. ref_ovf does not set.
- Interval: with no blocking, a refresh is granted within 1 cycle of ref_req rising.
- The first ref_req rises CNT_REF cycles after leaving INIT.
- Asserting rst_n low mid-transaction returns to INIT immediately. All grants drop asynchronously and the bus reverts to the init sequencer.

## Configuration
- SDRAM_RD_FIRST_EN:
  - Defined: ARBIT priority is ref_req > rd_req > wr_req.
  - Undefined (default): ref_req > wr_req > rd_req.
- Refresh always has top priority in both builds.

## Test plan
- Reset, then flag_init_end=1 at cycle 20: sdram_cmd tracks init_cmd until the edge, then is 4'b0111 in ARBIT. The first ref_req rises 780 cycles later.
- wr_req and rd_req both high in ARBIT: wr_en is granted; after the wr_end pulse there is one ARBIT cycle, then rd_en. With SDRAM_RD_FIRST_EN the order is reversed.
- ref_req rises during WRITE: no preemption. After wr_end, aref_en is granted ahead of a pending rd_req, and ref_req clears on AREF entry.
- WRITE held for more than 2×CNT_REF cycles (wr_end withheld): ref_ovf goes to 1 and stays 1 after the subsequent refresh.
- Timer wrap on the same edge as ARBIT→AREF: ref_req=1 afterwards, ref_ovf=0.
- rst_n pulsed low during READ: rd_en goes to 0 immediately, state returns to INIT, the counter returns to 0, and re-init proceeds normally.
